// File: rtl/bounded_count_sched_if.sv
// rtl/bounded_count_sched_if.sv - request/grant/counter bundle for the bounded count scheduler
interface bounded_count_sched_if #(
    parameter int N = 4,
    parameter int W = 11
);
    logic [N-1:0]   req;
    logic [N*W-1:0] limit;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   c;
    logic           clamp;

    modport master (
        output req, limit,
        input  gnt, done, busy, c, clamp
    );

    modport slave (
        input  req, limit,
        output gnt, done, busy, c, clamp
    );
endinterface

// File: rtl/bounded_count_sched.sv
// rtl/bounded_count_sched.sv - round-robin scheduler sharing one saturating counter; optional CNT_ABORT_EN
module bounded_count_sched #(
    parameter int N   = 4,
    parameter int W   = 11,
    parameter int CAP = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    bounded_count_sched_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   c_q, c_d;
    logic           clamp_q, clamp_d;
    logic [W-1:0]   lim_q, lim_d;
    logic [IW-1:0]  g_q, g_d;
    logic [IW-1:0]  rr_q, rr_d;

    logic           found;
    logic [IW-1:0]  pick;
    logic [W-1:0]   pick_limit;
    logic [IW-1:0]  g_next;
    logic [N-1:0]   g_onehot;
    logic [N-1:0]   pick_onehot;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CAP_W = W'(CAP);

    // Round-robin pick: first set request at or above the pointer, wrapping at N
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req[IW'((int'(rr_q) + k) % N)]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_q) + k) % N);
            end
        end
    end

    assign pick_limit  = bus.limit[int'(pick)*W +: W];
    assign pick_onehot = ONE << pick;
    assign g_onehot    = ONE << g_q;
    assign g_next      = IW'((int'(g_q) + 1) % N);

    // Next-state and datapath sequencing for the counting window
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        busy_d  = busy_q;
        c_d     = c_q;
        clamp_d = clamp_q;
        lim_d   = lim_q;
        g_d     = g_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    g_d     = pick;
                    lim_d   = (pick_limit > CAP_W) ? CAP_W : pick_limit;
                    clamp_d = (pick_limit > CAP_W);
                    gnt_d   = pick_onehot;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
`ifdef CNT_ABORT_EN
                if (!bus.req[g_q]) begin
                    // Owner withdrew: release without a done pulse, counter keeps its value
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    rr_d    = g_next;
                    state_d = IDLE;
                end else if (c_q != lim_q) begin
                    c_d = c_q + 1'b1;
                end else begin
                    gnt_d   = '0;
                    done_d  = g_onehot;
                    state_d = DONE;
                end
`else
                if (c_q != lim_q) begin
                    c_d = c_q + 1'b1;
                end else begin
                    gnt_d   = '0;
                    done_d  = g_onehot;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                done_d  = '0;
                busy_d  = 1'b0;
                rr_d    = g_next;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            c_q     <= '0;
            clamp_q <= 1'b0;
            lim_q   <= '0;
            g_q     <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            c_q     <= c_d;
            clamp_q <= clamp_d;
            lim_q   <= lim_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.c     = c_q;
    assign bus.clamp = clamp_q;
endmodule

// File: tb/tb_bounded_count_sched.sv
// tb/tb_bounded_count_sched.sv - self-checking bench for bounded_count_sched
module tb_bounded_count_sched;
    localparam int N   = 4;
    localparam int W   = 11;
    localparam int CAP = 200;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bounded_count_sched_if #(.N(N), .W(W)) bus ();

    bounded_count_sched #(.N(N), .W(W), .CAP(CAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] limit;
        int             g;
        int             lim;
        bit             clamp;
    } vec_t;

    typedef struct {
        int g;
        int lim;
        bit clamp;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t vecs[8];

    function automatic logic [N*W-1:0] pl(input int a, input int b, input int cc, input int d);
        logic [W-1:0] x0, x1, x2, x3;
        x0 = a[W-1:0];
        x1 = b[W-1:0];
        x2 = cc[W-1:0];
        x3 = d[W-1:0];
        return {x3, x2, x1, x0};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic run_window(input logic [N-1:0] r, input logic [N*W-1:0] lv,
                              input int eg, input int el, input bit ecl,
                              input bit hold, input int drop_at);
        exp_t         e;
        int           waitc;
        int           cnt;
        int           bad_c;
        logic [N-1:0] one;
        logic [N-1:0] oh;
        bus.req   = r;
        bus.limit = lv;
        sb.push_back('{eg, el, ecl});
        waitc = 0;
        while (bus.gnt == '0 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        e = sb.pop_front();
        if (bus.gnt == '0) begin
            timeout_fail("grant_wait");
            bus.req = '0;
            return;
        end
        one = 1;
        oh  = one << e.g;
        chk("gnt_onehot", bus.gnt, oh);
        chk("clamp", bus.clamp, e.clamp);
        chk("busy_count", bus.busy, 1);
        cnt   = 0;
        bad_c = -1;
        while (bus.gnt == oh && cnt < 300) begin
            if (bus.c != cnt && bad_c < 0) bad_c = cnt;
            if (drop_at >= 0 && bus.c == drop_at) bus.req[e.g] = 1'b0;
            cnt++;
            @(negedge clk);
        end
        chk("c_ramp_first_bad", bad_c, -1);
        chk("gnt_cycles", cnt, e.lim + 1);
        chk("done_pulse", bus.done, oh);
        chk("c_final", bus.c, e.lim);
        chk("busy_done", bus.busy, 1);
        if (!hold) bus.req = '0;
        @(negedge clk);
        chk("done_clear", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("c_hold", bus.c, e.lim);
    endtask

    initial begin
        int w;
        int seen;
        rst       = 1'b1;
        bus.req   = '0;
        bus.limit = '0;

        vecs[0] = '{4'b0001, pl(5, 0, 0, 0),       0, 5,   1'b0};
        vecs[1] = '{4'b0010, pl(0, 1500, 0, 0),    1, 200, 1'b1};
        vecs[2] = '{4'b0100, pl(0, 0, 0, 0),       2, 0,   1'b0};
        vecs[3] = '{4'b1000, pl(0, 0, 0, 3),       3, 3,   1'b0};
        vecs[4] = '{4'b0110, pl(1, 1, 1, 1),       1, 1,   1'b0};
        vecs[5] = '{4'b0011, pl(200, 9, 0, 0),     0, 200, 1'b0};
        vecs[6] = '{4'b0011, pl(4, 201, 0, 0),     1, 200, 1'b1};
        vecs[7] = '{4'b1001, pl(2, 0, 0, 7),       3, 7,   1'b0};

        repeat (2) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_c", bus.c, 0);
        chk("rst_clamp", bus.clamp, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req_gnt", bus.gnt, 0);

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].req, vecs[i].limit, vecs[i].g, vecs[i].lim, vecs[i].clamp, 1'b0, -1);
        end

        // All requesting continuously: strict rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            run_window(4'b1111, pl(2, 2, 2, 2), i % N, 2, 1'b0, (i < 4), -1);
        end

        // Reset in the middle of a window
        bus.req   = 4'b0100;
        bus.limit = pl(0, 0, 100, 0);
        w = 0;
        while (bus.c != 37 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (bus.c != 37) begin
            timeout_fail("reach_c37");
        end else begin
            #1 rst = 1'b1;
            #1;
            chk("midrst_gnt", bus.gnt, 0);
            chk("midrst_c", bus.c, 0);
            chk("midrst_busy", bus.busy, 0);
        end
        @(negedge clk);
        rst     = 1'b0;
        bus.req = '0;
        seen    = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done != '0) seen++;
        end
        chk("midrst_no_done", seen, 0);
        run_window(4'b1111, pl(3, 3, 3, 3), 0, 3, 1'b0, 1'b0, -1);

        // Owner drops its request mid-window
`ifdef CNT_ABORT_EN
        bus.req   = 4'b0001;
        bus.limit = pl(15, 0, 0, 0);
        w = 0;
        while (bus.c != 10 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (bus.c != 10 || bus.gnt != 4'b0001) begin
            timeout_fail("reach_c10");
        end else begin
            bus.req = '0;
            @(negedge clk);
            chk("abort_gnt", bus.gnt, 0);
            chk("abort_c", bus.c, 10);
            chk("abort_busy", bus.busy, 0);
            seen = 0;
            repeat (4) begin
                if (bus.done != '0) seen++;
                @(negedge clk);
            end
            chk("abort_no_done", seen, 0);
        end
`else
        run_window(4'b0001, pl(15, 0, 0, 0), 0, 15, 1'b0, 1'b0, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
